// File: rtl/s2mm.sv
// s2mm: writes an AXI4-Stream video frame into memory as AXI4 INCR bursts.
// Pixels are packed LSB-first into data words and staged in a word FIFO ahead of the burst engine.
module s2mm #(
    parameter int C_PIXEL_WIDTH      = 8,
    parameter int C_IMG_WBITS        = 12,
    parameter int C_IMG_HBITS        = 12,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              soft_resetn,
    output logic                              resetting,
    input  logic [C_IMG_WBITS-1:0]            img_width,
    input  logic [C_IMG_HBITS-1:0]            img_height,
    input  logic                              fsync,
    output logic                              w_sof,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     w_addr,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_PIXEL_WIDTH-1:0]          s_axis_tdata,
    input  logic                              s_axis_tuser,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awlock,
    output logic [3:0]                        m_axi_awcache,
    output logic [2:0]                        m_axi_awprot,
    output logic [3:0]                        m_axi_awqos,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic                              frame_done,
    output logic                              wr_err
);

    localparam int PW       = C_PIXEL_WIDTH;
    localparam int DW       = C_M_AXI_DATA_WIDTH;
    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int PPW      = DW / PW;
    localparam int BYTES    = DW / 8;
    localparam int SIZE     = $clog2(BYTES);
    localparam int PPW_BITS = $clog2(PPW);
    localparam int PIX_CW   = (PPW > 1) ? PPW_BITS : 1;
    localparam int BL       = C_M_AXI_BURST_LEN;
    localparam int DEPTH    = 2 * BL;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int TW       = C_IMG_WBITS + C_IMG_HBITS;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_ADDR = 2'd1;
    localparam logic [1:0] B_DATA = 2'd2;
    localparam logic [1:0] B_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     base_q;
    logic [TW-1:0]     total_q;
    logic [TW-1:0]     pushed_q;
    logic [PIX_CW-1:0] pixCnt_q;
    logic [DW-1:0]     wordBuf_q;
    logic              resetting_q;
    logic              wrErr_q;

    logic [1:0]        bState_q, bState_d;
    logic [TW-1:0]     issued_q;
    logic [AW-1:0]     awaddr_q;
    logic [7:0]        awlen_q;
    logic [7:0]        beatCnt_q;

    logic [DW-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [PTR_W:0]    count_q;

    logic              startFrame;
    logic              acceptPix;
    logic              readyPix;
    logic              pixLast;
    logic              pushWord;
    logic              popWord;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [DW-1:0]     pushData;
    logic [TW-1:0]     frameWords;
    logic [TW-1:0]     remaining;
    logic [8:0]        burstBeats;
    logic              burstReady;
    logic              issueBurst;
    logic              frameComplete;
    logic              unusedBits;

    // Word count per frame: pixels / PPW, PPW being a power of two.
    assign frameWords = TW'((TW'(img_width) * TW'(img_height)) >> PPW_BITS);
    assign pushData   = {s_axis_tdata, wordBuf_q[DW-1:PW]};
    assign pixLast    = (pixCnt_q == PIX_CW'(PPW - 1));
    assign pushWord   = acceptPix && pixLast;
    assign popWord    = m_axi_wvalid && m_axi_wready;
    assign fifoFull   = (count_q == (PTR_W+1)'(DEPTH));
    assign fifoEmpty  = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        startFrame = 1'b0;
        acceptPix  = 1'b0;
        readyPix   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (fsync && soft_resetn) begin
                    startFrame = 1'b1;
                    state_d    = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    acceptPix = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (pushed_q == total_q) begin
                    readyPix = 1'b0;
                    state_d  = S_FLUSH;
                end else begin
                    readyPix  = ~fifoFull;
                    acceptPix = s_axis_tvalid && ~fifoFull;
                end
            end
            S_FLUSH: begin
                if (frameComplete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            pushed_q    <= '0;
            pixCnt_q    <= '0;
            wordBuf_q   <= '0;
            resetting_q <= 1'b0;
            wrErr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (startFrame) begin
                base_q   <= w_addr;
                total_q  <= frameWords;
                pushed_q <= '0;
                pixCnt_q <= '0;
            end
            if (acceptPix) begin
                wordBuf_q <= pushData;
                pixCnt_q  <= pixLast ? '0 : pixCnt_q + 1'b1;
            end
            if (pushWord) begin
                pushed_q <= pushed_q + 1'b1;
            end
            // The frame in flight always completes; resetting just reports that wait.
            if (frame_done) begin
                resetting_q <= 1'b0;
            end else if (!soft_resetn && state_q != S_IDLE) begin
                resetting_q <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready && m_axi_bresp != 2'b00) begin
                wrErr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushWord) begin
            mem[wrPtr_q] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushWord) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popWord) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushWord, popWord})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A burst is full length while enough words remain, otherwise it carries the frame tail.
    assign remaining  = total_q - issued_q;
    assign burstBeats = (remaining >= TW'(BL)) ? 9'(BL) : 9'(remaining);
    assign burstReady = (state_q == S_RUN || state_q == S_FLUSH) && (remaining != '0)
                        && (9'(count_q) >= burstBeats);
    assign frameComplete = (issued_q == total_q) && (bState_q == B_IDLE);

    always_comb begin
        bState_d   = bState_q;
        issueBurst = 1'b0;
        case (bState_q)
            B_IDLE: begin
                if (burstReady) begin
                    issueBurst = 1'b1;
                    bState_d   = B_ADDR;
                end
            end
            B_ADDR: begin
                if (m_axi_awready) begin
                    bState_d = B_DATA;
                end
            end
            B_DATA: begin
                if (popWord && m_axi_wlast) begin
                    bState_d = B_RESP;
                end
            end
            B_RESP: begin
                if (m_axi_bvalid) begin
                    bState_d = B_IDLE;
                end
            end
            default: bState_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bState_q  <= B_IDLE;
            issued_q  <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            bState_q <= bState_d;
            if (startFrame) begin
                issued_q <= '0;
            end
            if (issueBurst) begin
                awaddr_q  <= base_q + (AW'(issued_q) << SIZE);
                awlen_q   <= 8'(burstBeats - 9'd1);
                issued_q  <= issued_q + TW'(burstBeats);
                beatCnt_q <= '0;
            end
            if (popWord) begin
                beatCnt_q <= beatCnt_q + 8'd1;
            end
        end
    end

    assign resetting     = resetting_q;
    assign w_sof         = startFrame;
    assign s_axis_tready = readyPix;
    assign frame_done    = (state_q == S_FLUSH) && frameComplete;
    assign wr_err        = wrErr_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = (bState_q == B_ADDR);

    // W outputs are gated so the idle bus never shows stale FIFO contents.
    assign m_axi_wvalid  = (bState_q == B_DATA) && !fifoEmpty;
    assign m_axi_wdata   = m_axi_wvalid ? mem[rdPtr_q] : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (bState_q == B_DATA) && (beatCnt_q == awlen_q);
    assign m_axi_bready  = 1'b1;

    assign unusedBits = ^{m_axi_bid, s_axis_tlast, wordBuf_q[PW-1:0]};

endmodule

// File: tb/tb_s2mm.sv
// tb_s2mm: directed frames into s2mm with a scoreboard of expected AW and W beats.
// A negedge monitor plays the AXI slave, pops the queues on every handshake and compares.
module tb_s2mm;

    logic        clk = 1'b0;
    logic        reset;
    logic        soft_resetn;
    logic        resetting;
    logic [11:0] img_width;
    logic [11:0] img_height;
    logic        fsync;
    logic        w_sof;
    logic [31:0] w_addr;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic [0:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [0:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic        frame_done;
    logic        wr_err;

    logic [31:0] expAwAddr[$];
    logic [7:0]  expAwLen[$];
    logic [31:0] expWData[$];
    bit          expWLast[$];

    int          assertCnt = 0;
    int          failCnt = 0;
    int          cyc = 0;
    int          bSetCyc = -10;
    int          frameDoneCnt = 0;
    int          wBeatCnt = 0;
    int          awCnt = 0;
    logic        bPending = 1'b0;
    logic [1:0]  bRespCfg = 2'b00;
    logic        wreadyEn = 1'b1;

    always #5 clk = ~clk;

    s2mm dut (
        .clk           (clk),
        .reset         (reset),
        .soft_resetn   (soft_resetn),
        .resetting     (resetting),
        .img_width     (img_width),
        .img_height    (img_height),
        .fsync         (fsync),
        .w_sof         (w_sof),
        .w_addr        (w_addr),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awqos   (m_axi_awqos),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .frame_done    (frame_done),
        .wr_err        (wr_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Slave side and monitor: inputs change at negedge, handshakes are judged 1 ns later.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_axi_bvalid = 1'b0;
            bPending     = 1'b0;
        end else if (m_axi_bvalid) begin
            m_axi_bvalid = 1'b0;
        end else if (bPending) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = bRespCfg;
            bPending     = 1'b0;
            bSetCyc      = cyc;
        end
        m_axi_wready = wreadyEn;
        #1;
        if (!reset) begin
            if (m_axi_awvalid && m_axi_awready) begin
                awCnt++;
                if (expAwAddr.size() == 0) begin
                    assertCnt++;
                    failCnt++;
                    $display("[TB] FAIL unexpectedAw: actual awaddr=0x%0h required no burst", m_axi_awaddr);
                end else begin
                    checkOutput("awaddr", m_axi_awaddr, expAwAddr.pop_front());
                    checkOutput("awlen", m_axi_awlen, expAwLen.pop_front());
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                wBeatCnt++;
                if (expWData.size() == 0) begin
                    assertCnt++;
                    failCnt++;
                    $display("[TB] FAIL unexpectedW: actual wdata=0x%0h required no beat", m_axi_wdata);
                end else begin
                    checkOutput("wdata", m_axi_wdata, expWData.pop_front());
                    checkOutput("wlast", m_axi_wlast, expWLast.pop_front());
                end
                if (m_axi_wlast) bPending = 1'b1;
            end
            if (frame_done) begin
                frameDoneCnt++;
                checkOutput("frameDoneLatency", cyc - bSetCyc, 1);
            end
        end
    end

    task automatic pushWords(input int words, input logic [7:0] firstVal);
        logic [31:0] wd;
        int pix = 0;
        for (int b = 0; b < words; b++) begin
            for (int k = 0; k < 4; k++) begin
                wd[k*8 +: 8] = firstVal + 8'(pix);
                pix++;
            end
            expWData.push_back(wd);
            expWLast.push_back((b % 16 == 15) || (b == words - 1));
        end
    endtask

    task automatic pushExpect(input logic [31:0] base, input int words, input logic [7:0] firstVal);
        int issued = 0;
        int beats;
        while (issued < words) begin
            beats = (words - issued >= 16) ? 16 : (words - issued);
            expAwAddr.push_back(base + 32'(issued * 4));
            expAwLen.push_back(8'(beats - 1));
            issued += beats;
        end
        pushWords(words, firstVal);
    endtask

    task automatic sendPixel(input logic [7:0] data, input logic user);
        logic hs;
        int guard = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tuser  = user;
        forever begin
            #1 hs = s_axis_tready;
            @(posedge clk);
            if (hs) break;
            guard++;
            if (guard > 3000) begin
                assertCnt++;
                failCnt++;
                $display("[TB] FAIL pixelTimeout: tready low for pixel 0x%0h, required a handshake", data);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic startFrame(input logic [31:0] base, input int w, input int h, input logic expectSof);
        @(negedge clk);
        w_addr     = base;
        img_width  = 12'(w);
        img_height = 12'(h);
        fsync      = 1'b1;
        #1 checkOutput("w_sof", w_sof, expectSof);
        @(negedge clk);
        fsync = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input int w, input int h, input int drops,
                                 input logic [7:0] firstVal);
        startFrame(base, w, h, 1'b1);
        for (int i = 0; i < drops; i++) begin
            #1 checkOutput("waitSofTready", s_axis_tready, 1);
            sendPixel(8'(17 * (i + 1)), 1'b0);
        end
        for (int i = 0; i < w * h; i++) begin
            sendPixel(firstVal + 8'(i), i == 0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic waitFrameDone(input string name, input int target);
        int n = 0;
        while (frameDoneCnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        #2;
        checkOutput(name, frameDoneCnt, target);
        checkOutput({name, "_awLeft"}, expAwAddr.size(), 0);
        checkOutput({name, "_wLeft"}, expWData.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wb0;
        int aw0;
        reset         = 1'b1;
        soft_resetn   = 1'b1;
        fsync         = 1'b0;
        w_addr        = '0;
        img_width     = '0;
        img_height    = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bid     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstTready", s_axis_tready, 1);
        checkOutput("rstAwvalid", m_axi_awvalid, 0);
        checkOutput("rstWvalid", m_axi_wvalid, 0);
        checkOutput("rstWlast", m_axi_wlast, 0);
        checkOutput("rstWsof", w_sof, 0);
        checkOutput("rstFrameDone", frame_done, 0);
        checkOutput("rstResetting", resetting, 0);
        checkOutput("rstWrErr", wr_err, 0);
        checkOutput("bready", m_axi_bready, 1);
        checkOutput("awsize", m_axi_awsize, 2);
        checkOutput("awburst", m_axi_awburst, 1);
        checkOutput("awcache", m_axi_awcache, 3);
        checkOutput("wstrb", m_axi_wstrb, 4'hF);

        $display("[TB] frame 1: 8x2 at 0x10000000");
        expAwAddr.push_back(32'h1000_0000); expAwLen.push_back(8'd3);
        expWData.push_back(32'h0403_0201); expWLast.push_back(1'b0);
        expWData.push_back(32'h0807_0605); expWLast.push_back(1'b0);
        expWData.push_back(32'h0C0B_0A09); expWLast.push_back(1'b0);
        expWData.push_back(32'h100F_0E0D); expWLast.push_back(1'b1);
        wb0 = wBeatCnt;
        applyStimulus(32'h1000_0000, 8, 2, 0, 8'h01);
        waitFrameDone("frameDone_t1", 1);
        checkOutput("beats_t1", wBeatCnt - wb0, 4);

        $display("[TB] frame 2: 64x2 at 0x20000000");
        expAwAddr.push_back(32'h2000_0000); expAwLen.push_back(8'd15);
        expAwAddr.push_back(32'h2000_0040); expAwLen.push_back(8'd15);
        pushWords(32, 8'h40);
        wb0 = wBeatCnt;
        aw0 = awCnt;
        applyStimulus(32'h2000_0000, 64, 2, 0, 8'h40);
        waitFrameDone("frameDone_t2", 2);
        checkOutput("beats_t2", wBeatCnt - wb0, 32);
        checkOutput("bursts_t2", awCnt - aw0, 2);

        $display("[TB] frame 3: 20x1 short burst");
        expAwAddr.push_back(32'h3000_0000); expAwLen.push_back(8'd4);
        pushWords(5, 8'h80);
        wb0 = wBeatCnt;
        applyStimulus(32'h3000_0000, 20, 1, 0, 8'h80);
        waitFrameDone("frameDone_t3", 3);
        checkOutput("beats_t3", wBeatCnt - wb0, 5);

        $display("[TB] frame 4: pixels before SOF are dropped");
        expAwAddr.push_back(32'h4000_0000); expAwLen.push_back(8'd1);
        expWData.push_back(32'hA3A2_A1A0); expWLast.push_back(1'b0);
        expWData.push_back(32'hA7A6_A5A4); expWLast.push_back(1'b1);
        applyStimulus(32'h4000_0000, 8, 1, 3, 8'hA0);
        waitFrameDone("frameDone_t4", 4);

        $display("[TB] frame 5: wready stalled, FIFO fills");
        pushExpect(32'h5000_0000, 64, 8'h00);
        wreadyEn = 1'b0;
        fork
            applyStimulus(32'h5000_0000, 64, 4, 0, 8'h00);
            begin
                repeat (200) @(negedge clk);
                #2;
                checkOutput("fullTready", s_axis_tready, 0);
                checkOutput("stallWvalid", m_axi_wvalid, 1);
                wreadyEn = 1'b1;
            end
        join
        waitFrameDone("frameDone_t5", 5);

        $display("[TB] frame 6: soft reset mid-frame, error response");
        bRespCfg = 2'b10;
        #1 checkOutput("wrErrBefore", wr_err, 0);
        pushExpect(32'h6000_0000, 4, 8'h30);
        startFrame(32'h6000_0000, 8, 2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) soft_resetn = 1'b0;
            if (i == 8) begin
                #1 checkOutput("resettingMid", resetting, 1);
            end
            sendPixel(8'h30 + 8'(i), i == 0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        waitFrameDone("frameDone_t6", 6);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resettingAfter", resetting, 0);
        checkOutput("wrErrSticky", wr_err, 1);
        aw0 = awCnt;
        startFrame(32'h7000_0000, 8, 2, 1'b0);
        repeat (30) @(negedge clk);
        #2;
        checkOutput("ignoredFsyncBursts", awCnt - aw0, 0);
        checkOutput("ignoredFsyncDone", frameDoneCnt, 6);
        checkOutput("resettingIdle", resetting, 0);
        checkOutput("idleTready", s_axis_tready, 1);
        soft_resetn = 1'b1;
        bRespCfg    = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
